// File: rtl/instr_mem_loadable.sv
// Instruction memory for the ihs core.
// Provides a 1-cycle synchronous fetch port and a streaming program-load port.
// While a load is in progress, fetches are dropped.
// Out-of-range fetches return NOP_WORD and raise fetch_fault.
module instr_mem_loadable #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_count,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state_q;
    logic                fetch_valid_q;
    logic [DATA_W-1:0]   instr_q;
    logic                fault_q;
    logic                ready_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W-1:0]   rem_q;

    // Array is not reset; the power-up image is all NOP_WORD.
    logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: NOP_WORD};

    logic                wr_en;
    logic [IDX_W-1:0]    fetch_idx;
    logic [IDX_W-1:0]    ptr_idx;

    // The range checks use one extra bit so that base+count cannot overflow.
    function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
        return {1'b0, a} >= DEPTH_X;
    endfunction

    function automatic logic load_range_bad(input logic [ADDR_W-1:0] base,
                                            input logic [ADDR_W-1:0] cnt);
        return (cnt == '0) || (({1'b0, base} + {1'b0, cnt}) > DEPTH_X);
    endfunction

    // The range check at load_start keeps ptr_q below DEPTH, so the low bits are a valid index.
    assign fetch_idx = fetch_addr[IDX_W-1:0];
    assign ptr_idx   = ptr_q[IDX_W-1:0];
    assign wr_en     = (state_q == LOAD) && ready_q && load_valid && !reset;

    // Write path: one program word per accepted load beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_idx] <= load_data;
        end
    end

    // Control FSM.
    // Drives the registered fetch result and the load handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_WORD;
            fault_q       <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            ptr_q         <= '0;
            rem_q         <= '0;
        end else begin
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch_req) begin
                        fetch_valid_q <= 1'b1;
                        if (addr_oob(fetch_addr)) begin
                            instr_q <= NOP_WORD;
                            fault_q <= 1'b1;
                        end else begin
                            instr_q <= mem_q[fetch_idx];
                            fault_q <= 1'b0;
                        end
                    end
                    if (load_start) begin
                        if (load_range_bad(load_base, load_count)) begin
                            err_q <= 1'b1;
                        end else begin
                            ptr_q   <= load_base;
                            rem_q   <= load_count;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                        rem_q <= rem_q - ADDR_W'(1);
                        if (rem_q == ADDR_W'(1)) begin
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign instruction = instr_q;
    assign fetch_fault = fault_q;
    assign load_ready  = ready_q;
    assign load_busy   = busy_q;
    assign load_done   = done_q;
    assign load_error  = err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable (DEPTH=16, 16-bit words/addresses).
module tb_instr_mem_loadable;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_valid;
    logic [15:0] instruction;
    logic        fetch_fault;
    logic        load_start;
    logic [15:0] load_base;
    logic [15:0] load_count;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    instr_mem_loadable #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(16), .NOP_WORD(16'h0000)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .instruction(instruction), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_base(load_base), .load_count(load_count),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .load_busy(load_busy),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        logic        fault;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] ldq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_cnt = 0;
    logic        mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch results are compared against the scoreboard as they appear.
    always @(negedge clk) begin
        if (mon_en) begin
            if (load_done) done_cnt++;
            if (fetch_valid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_fetch", 32'(fetch_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("fetch_instr", 32'(instruction), 32'(e.instr));
                    check("fetch_fault", 32'(fetch_fault), 32'(e.fault));
                end
            end
        end
    end

    // Issue one fetch, queue its expected result and check that the result arrives one cycle later.
    task automatic fetch_one(input logic [15:0] addr, input logic [15:0] ins, input logic flt);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = addr;
        e.instr    = ins;
        e.fault    = flt;
        sb.push_back(e);
        tick();
        check("fetch_valid_latency", 32'(fetch_valid), 32'd1);
    endtask

    // Stream every word in ldq into the memory, starting at base, and check the load handshake.
    task automatic load_prog(input logic [15:0] base);
        load_start = 1'b1;
        load_base  = base;
        load_count = 16'(ldq.size());
        tick();
        load_start = 1'b0;
        check("load_busy_start", 32'(load_busy), 32'd1);
        while (ldq.size() > 0) begin
            check("load_ready", 32'(load_ready), 32'd1);
            load_valid = 1'b1;
            load_data  = ldq.pop_front();
            tick();
        end
        load_valid = 1'b0;
        check("load_done_pulse", 32'(load_done), 32'd1);
        check("load_busy_done", 32'(load_busy), 32'd0);
        tick();
        check("load_done_clear", 32'(load_done), 32'd0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'd0,     16'hA005, 1'b0};
        tbl[1] = '{16'd1,     16'hA203, 1'b0};
        tbl[2] = '{16'd2,     16'hA400, 1'b0};
        tbl[3] = '{16'd3,     16'h0000, 1'b0};
        tbl[4] = '{16'd15,    16'h0000, 1'b0};
        tbl[5] = '{16'd16,    16'h0000, 1'b1};
        tbl[6] = '{16'hFFFF,  16'h0000, 1'b1};
        tbl[7] = '{16'd1,     16'hA203, 1'b0};

        // Reset is held for two cycles while the other inputs are driven with random values.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_req  = 1'($urandom);
            fetch_addr = 16'($urandom);
            load_start = 1'($urandom);
            load_base  = 16'($urandom);
            load_count = 16'($urandom);
            load_valid = 1'($urandom);
            load_data  = 16'($urandom);
            tick();
        end
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_instruction", 32'(instruction), 32'h0000);
        check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        check("rst_load_ready",  32'(load_ready),  32'd0);
        check("rst_load_busy",   32'(load_busy),   32'd0);
        check("rst_load_done",   32'(load_done),   32'd0);
        check("rst_load_error",  32'(load_error),  32'd0);
        fetch_req = 1'b0; load_start = 1'b0; load_valid = 1'b0;
        fetch_addr = '0; load_base = '0; load_count = '0; load_data = '0;
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Load three words at base 0, with a one-cycle gap in load_valid.
        load_start = 1'b1; load_base = 16'd0; load_count = 16'd3;
        tick();
        load_start = 1'b0;
        check("t2_busy", 32'(load_busy), 32'd1);
        check("t2_ready", 32'(load_ready), 32'd1);
        load_valid = 1'b1; load_data = 16'hA005; tick();
        load_valid = 1'b0; tick();
        check("t2_gap_busy", 32'(load_busy), 32'd1);
        check("t2_gap_done", 32'(load_done), 32'd0);
        load_valid = 1'b1; load_data = 16'hA203; tick();
        check("t2_done_early", 32'(load_done), 32'd0);
        load_data = 16'hA400; tick();
        load_valid = 1'b0;
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_ready_off", 32'(load_ready), 32'd0);
        tick();
        check("t2_done_clear", 32'(load_done), 32'd0);

        // Back-to-back fetches from the vector table, including out-of-range addresses.
        for (int i = 0; i < 8; i++) fetch_one(tbl[i].addr, tbl[i].instr, tbl[i].fault);
        fetch_req = 1'b0;
        tick();
        check("hold_valid", 32'(fetch_valid), 32'd0);
        check("hold_instr", 32'(instruction), 32'hA203);
        check("hold_fault", 32'(fetch_fault), 32'd0);

        // Rejected loads: the range runs past DEPTH, or the count is zero.
        load_start = 1'b1; load_base = 16'd14; load_count = 16'd3;
        tick();
        check("t4_err_range", 32'(load_error), 32'd1);
        check("t4_busy", 32'(load_busy), 32'd0);
        load_base = 16'd0; load_count = 16'd0;
        tick();
        check("t4_err_zero", 32'(load_error), 32'd1);
        load_start = 1'b0;
        tick();
        check("t4_err_clear", 32'(load_error), 32'd0);
        check("t4_ready", 32'(load_ready), 32'd0);
        fetch_one(16'd14, 16'h0000, 1'b0);
        fetch_one(16'd15, 16'h0000, 1'b0);
        fetch_req = 1'b0;
        tick();

        // Pre-fill words 6 and 7.
        // Then abort a 4-word load at base 4 with reset after two accepted words.
        ldq.push_back(16'hC006); ldq.push_back(16'hC007);
        load_prog(16'd6);
        load_start = 1'b1; load_base = 16'd4; load_count = 16'd4;
        tick();
        load_start = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'd0;
        load_valid = 1'b1; load_data = 16'hD004; tick();
        check("t5_fetch_in_load", 32'(fetch_valid), 32'd0);
        load_data = 16'hD005; tick();
        check("t5_fetch_in_load2", 32'(fetch_valid), 32'd0);
        fetch_req = 1'b0; load_valid = 1'b0;
        reset = 1'b1; tick();
        reset = 1'b0;
        check("t5_busy_abort", 32'(load_busy), 32'd0);
        check("t5_ready_abort", 32'(load_ready), 32'd0);
        tick();
        check("t5_done_count", 32'(done_cnt), 32'd2);
        fetch_one(16'd4, 16'hD004, 1'b0);
        fetch_one(16'd5, 16'hD005, 1'b0);
        fetch_one(16'd6, 16'hC006, 1'b0);
        fetch_one(16'd7, 16'hC007, 1'b0);
        fetch_req = 1'b0;
        tick();

        // A fetch and a load_start issued in the same IDLE cycle.
        begin
            exp_t e;
            e.instr = 16'hA400; e.fault = 1'b0;
            sb.push_back(e);
        end
        fetch_req = 1'b1; fetch_addr = 16'd2;
        load_start = 1'b1; load_base = 16'd8; load_count = 16'd1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        check("t6_fetch_valid", 32'(fetch_valid), 32'd1);
        check("t6_busy", 32'(load_busy), 32'd1);
        load_valid = 1'b1; load_data = 16'hE008; tick();
        load_valid = 1'b0;
        check("t6_done", 32'(load_done), 32'd1);
        tick();
        fetch_one(16'd8, 16'hE008, 1'b0);
        fetch_req = 1'b0;

        // Give any remaining scoreboard entries a bounded number of cycles to drain.
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        tick();
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
